// File: rtl/onehot_player_pkg.sv
// Shared types and constants for the one-hot code player.
package onehot_player_pkg;

  localparam int CODE_W = 3;
  localparam int PAT_W  = 8;
  localparam int ENTRY_W = CODE_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // An unflagged entry decodes to the all-off pattern.
  function automatic logic [PAT_W-1:0] onehot_decode(input logic flag,
                                                     input logic [CODE_W-1:0] code);
    logic [PAT_W-1:0] pat;
    pat = '0;
    if (flag) pat = PAT_W'(1) << code;
    return pat;
  endfunction

endpackage

// File: rtl/onehot_player_if.sv
// Producer-side handshake bundle: code entry plus ready back-pressure.
interface onehot_player_if;
  import onehot_player_pkg::*;

  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              in_flag;
  logic              in_ready;

  modport master (output in_valid, output in_code, output in_flag, input in_ready);
  modport slave  (input in_valid, input in_code, input in_flag, output in_ready);
endinterface

// File: rtl/onehot_player_fifo.sv
// Circular FIFO of {flag,code} entries; head is visible combinationally.
module onehot_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/onehot_player.sv
// Queues {flag,code} entries and shows each as a one-hot pattern for HOLD_CYCLES cycles.
module onehot_player
  import onehot_player_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  onehot_player_if.slave         in_bus,
  output logic [PAT_W-1:0]       sw_out,
  output logic                   out_active,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [FCW-1:0] FULL_CNT  = FCW'(DEPTH);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  state_t             state;
  state_t             state_n;
  logic [HCW-1:0]     hold_cnt;
  logic               pop;
  logic               push;
  logic [ENTRY_W-1:0] head;

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
  assign in_bus.in_ready = (fifo_count < FULL_CNT);
  assign push            = in_bus.in_valid && in_bus.in_ready;

  onehot_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_bus.in_flag, in_bus.in_code}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (fifo_count != '0) pop = 1'b1;
          else                  state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Display register: loaded on every pop, cleared when falling back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      sw_out     <= '0;
      out_active <= 1'b0;
      busy       <= 1'b0;
    end else if (pop) begin
      hold_cnt   <= HOLD_LOAD;
      sw_out     <= onehot_decode(head[ENTRY_W-1], head[CODE_W-1:0]);
      out_active <= head[ENTRY_W-1];
      busy       <= 1'b1;
    end else if (state == HOLD) begin
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end else begin
        sw_out     <= '0;
        out_active <= 1'b0;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_player.sv
// Directed bench for onehot_player: one instance with 8-cycle hold, one with 1-cycle hold.
module tb_onehot_player;
  import onehot_player_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_player_if bus8 ();
  onehot_player_if bus1 ();

  logic [7:0] sw8, sw1;
  logic       act8, act1, busy8, busy1;
  logic [2:0] cnt8, cnt1;

  int vecs = 0;
  int errs = 0;

  onehot_player #(.DEPTH(4), .HOLD_CYCLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_bus(bus8.slave),
    .sw_out(sw8), .out_active(act8), .busy(busy8), .fifo_count(cnt8)
  );

  onehot_player #(.DEPTH(4), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_bus(bus1.slave),
    .sw_out(sw1), .out_active(act1), .busy(busy1), .fifo_count(cnt1)
  );

  task automatic test_reset();
    rst = 1'b1;
    bus8.in_valid = 1'b1; bus8.in_flag = 1'b1; bus8.in_code = 3'd6;
    bus1.in_valid = 1'b1; bus1.in_flag = 1'b1; bus1.in_code = 3'd6;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    vecs++; if (sw8 !== 8'h00) begin errs++; $display("FAIL reset_sw_out: got %h want 00", sw8); end
    vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy8); end
    vecs++; if (act8 !== 1'b0) begin errs++; $display("FAIL reset_out_active: got %b want 0", act8); end
    vecs++; if (bus8.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready); end
    vecs++; if (cnt8 !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", cnt8); end
    vecs++; if (cnt1 !== 3'd0) begin errs++; $display("FAIL reset_count_h1: got %0d want 0", cnt1); end
    @(negedge clk);
    vecs++; if (sw8 !== 8'h00 || busy8 !== 1'b0) begin errs++; $display("FAIL reset_idle_after: got sw %h busy %b want 00 0", sw8, busy8); end
  endtask

  task automatic test_single();
    bus8.in_valid = 1'b1; bus8.in_flag = 1'b1; bus8.in_code = 3'd5;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    vecs++; if (cnt8 !== 3'd1) begin errs++; $display("FAIL single_count_after_push: got %0d want 1", cnt8); end
    vecs++; if (sw8 !== 8'h00 || busy8 !== 1'b0) begin errs++; $display("FAIL single_latency: got sw %h busy %b want 00 0", sw8, busy8); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vecs++;
      if (sw8 !== 8'h20 || act8 !== 1'b1 || busy8 !== 1'b1) begin
        errs++; $display("FAIL single_hold[%0d]: got sw %h act %b busy %b want 20 1 1", i, sw8, act8, busy8);
      end
    end
    @(negedge clk);
    vecs++;
    if (sw8 !== 8'h00 || act8 !== 1'b0 || busy8 !== 1'b0) begin
      errs++; $display("FAIL single_end: got sw %h act %b busy %b want 00 0 0", sw8, act8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int e = 1; e <= 42; e++) begin
      if (e <= 5) begin
        bus8.in_valid = 1'b1; bus8.in_flag = 1'b1; bus8.in_code = 3'(e - 1);
      end else if (e == 6) begin
        bus8.in_valid = 1'b1; bus8.in_flag = 1'b1; bus8.in_code = 3'd7;
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(negedge clk);
      exp = (e >= 2 && e <= 41) ? (8'h01 << ((e - 2) / 8)) : 8'h00;
      vecs++;
      if (sw8 !== exp || busy8 !== (exp != 8'h00)) begin
        errs++; $display("FAIL b2b_seq[edge %0d]: got sw %h busy %b want %h %b", e, sw8, busy8, exp, exp != 8'h00);
      end
      if (e == 5 || e == 6) begin
        vecs++;
        if (cnt8 !== 3'd4 || bus8.in_ready !== 1'b0) begin
          errs++; $display("FAIL b2b_full[edge %0d]: got count %0d ready %b want 4 0", e, cnt8, bus8.in_ready);
        end
      end
    end
    vecs++; if (cnt8 !== 3'd0) begin errs++; $display("FAIL b2b_drained: got %0d want 0", cnt8); end
  endtask

  task automatic test_noflag();
    bus8.in_valid = 1'b1; bus8.in_flag = 1'b0; bus8.in_code = 3'd7;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL noflag_latency: got busy %b want 0", busy8); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vecs++;
      if (sw8 !== 8'h00 || act8 !== 1'b0 || busy8 !== 1'b1) begin
        errs++; $display("FAIL noflag_hold[%0d]: got sw %h act %b busy %b want 00 0 1", i, sw8, act8, busy8);
      end
    end
    @(negedge clk);
    vecs++; if (busy8 !== 1'b0) begin errs++; $display("FAIL noflag_end: got busy %b want 0", busy8); end
  endtask

  task automatic test_hold1();
    logic [2:0] codes [4];
    logic [7:0] exp [6];
    codes = '{3'd7, 3'd6, 3'd1, 3'd0};
    exp   = '{8'h00, 8'h80, 8'h40, 8'h02, 8'h01, 8'h00};
    for (int e = 0; e < 6; e++) begin
      if (e < 4) begin
        bus1.in_valid = 1'b1; bus1.in_flag = 1'b1; bus1.in_code = codes[e];
      end else begin
        bus1.in_valid = 1'b0;
      end
      @(negedge clk);
      vecs++;
      if (sw1 !== exp[e] || act1 !== (exp[e] != 8'h00) || busy1 !== (exp[e] != 8'h00)) begin
        errs++; $display("FAIL hold1_seq[%0d]: got sw %h act %b busy %b want %h", e, sw1, act1, busy1, exp[e]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [2:0] codes [3];
    codes = '{3'd2, 3'd3, 3'd4};
    for (int e = 0; e < 3; e++) begin
      bus8.in_valid = 1'b1; bus8.in_flag = 1'b1; bus8.in_code = codes[e];
      @(negedge clk);
    end
    bus8.in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (sw8 !== 8'h04 || cnt8 !== 3'd2) begin
      errs++; $display("FAIL midrst_pre: got sw %h count %0d want 04 2", sw8, cnt8);
    end
    rst = 1'b1;
    bus8.in_valid = 1'b1; bus8.in_flag = 1'b1; bus8.in_code = 3'd6;
    @(negedge clk);
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    vecs++;
    if (sw8 !== 8'h00 || cnt8 !== 3'd0 || busy8 !== 1'b0 || bus8.in_ready !== 1'b1) begin
      errs++; $display("FAIL midrst_cleared: got sw %h count %0d busy %b ready %b want 00 0 0 1", sw8, cnt8, busy8, bus8.in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vecs++;
      if (sw8 !== 8'h00 || cnt8 !== 3'd0) begin
        errs++; $display("FAIL midrst_quiet[%0d]: got sw %h count %0d want 00 0", i, sw8, cnt8);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_flag = 1'b0; bus8.in_code = 3'd0;
    bus1.in_valid = 1'b0; bus1.in_flag = 1'b0; bus1.in_code = 3'd0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_noflag();
    test_hold1();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
